// File: rtl/dds_phase_detector.sv
// Vectoring CORDIC phase detector: converts a signed I/Q sample into its full-circle
// phase (same format as the DDS phase input) and its unscaled magnitude.
module dds_phase_detector #(
  parameter int IN_DW      = 16,
  parameter int PHASE_DW   = 16,
  parameter int ITERATIONS = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [2*IN_DW-1:0]    s_axis_in_tdata,
  input  logic                  s_axis_in_tvalid,
  output logic                  s_axis_in_tready,
  output logic [PHASE_DW-1:0]   m_axis_out_phase_tdata,
  output logic [IN_DW:0]        m_axis_out_mag_tdata,
  output logic                  m_axis_out_tvalid,
  input  logic                  m_axis_out_tready
);

  localparam int XW    = IN_DW + 3;
  localparam int CNT_W = $clog2(ITERATIONS + 1);
  localparam int TAB_N = 1 << CNT_W;

  function automatic logic [PHASE_DW-1:0] atan_val(input int i);
    real a;
    a = $atan(2.0 ** (-i)) * (2.0 ** PHASE_DW) / (2.0 * 3.14159265358979323846);
    return PHASE_DW'($rtoi(a + 0.5));
  endfunction

  typedef enum logic [1:0] {IDLE, ROTATE, HOLD} state_t;

  state_t                     state, state_nxt;
  logic [CNT_W-1:0]           iter;
  logic signed [XW-1:0]       x, y, x_shr, y_shr;
  logic signed [XW-1:0]       i_ext, q_ext;
  logic [PHASE_DW-1:0]        z;
  logic                       zero_in;
  logic [PHASE_DW-1:0]        atan_tab [TAB_N];

  for (genvar g = 0; g < TAB_N; g++) begin : g_atan
    localparam logic [PHASE_DW-1:0] A = (g < ITERATIONS) ? atan_val(g) : '0;
    assign atan_tab[g] = A;
  end

  assign i_ext = XW'(signed'(s_axis_in_tdata[IN_DW-1:0]));
  assign q_ext = XW'(signed'(s_axis_in_tdata[2*IN_DW-1:IN_DW]));
  assign x_shr = x >>> iter;
  assign y_shr = y >>> iter;

  always_comb begin
    state_nxt         = state;
    s_axis_in_tready  = 1'b0;
    m_axis_out_tvalid = 1'b0;
    case (state)
      IDLE: begin
        s_axis_in_tready = !reset;
        if (s_axis_in_tvalid) state_nxt = ROTATE;
      end
      ROTATE: begin
        if (iter == CNT_W'(ITERATIONS)) state_nxt = HOLD;
      end
      HOLD: begin
        m_axis_out_tvalid = 1'b1;
        if (m_axis_out_tready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // control: FSM, iteration counter and result registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state                  <= IDLE;
      iter                   <= '0;
      m_axis_out_phase_tdata <= '0;
      m_axis_out_mag_tdata   <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE)
        iter <= '0;
      else if (state == ROTATE && iter != CNT_W'(ITERATIONS))
        iter <= iter + 1'b1;
      if (state == ROTATE && state_nxt == HOLD) begin
        // an all-zero vector has no angle; the rotations would drift z, so force 0
        m_axis_out_phase_tdata <= zero_in ? '0 : z;
        m_axis_out_mag_tdata   <= x[IN_DW:0];
      end
    end
  end

  // datapath: pre-rotation into the right half-plane, then micro-rotations
  always_ff @(posedge clk) begin
    if (state == IDLE && s_axis_in_tvalid) begin
      zero_in <= (i_ext == '0) && (q_ext == '0);
      if (i_ext < 0) begin
        x <= -i_ext;
        y <= -q_ext;
        z <= {1'b1, {(PHASE_DW-1){1'b0}}};
      end else begin
        x <= i_ext;
        y <= q_ext;
        z <= '0;
      end
    end else if (state == ROTATE && iter != CNT_W'(ITERATIONS)) begin
      if (!y[XW-1]) begin
        x <= x + y_shr;
        y <= y - x_shr;
        z <= z + atan_tab[iter];
      end else begin
        x <= x - y_shr;
        y <= y + x_shr;
        z <= z - atan_tab[iter];
      end
    end
  end

endmodule

// File: tb/tb_dds_phase_detector.sv
// Directed bench for dds_phase_detector: axis points, synthetic DDS loopback phases,
// output backpressure and mid-rotation reset.
module tb_dds_phase_detector;
  localparam int IN_DW      = 16;
  localparam int PHASE_DW   = 16;
  localparam int ITERATIONS = 14;
  localparam real PI = 3.14159265358979323846;

  logic                clk = 1'b0;
  logic                reset;
  logic [2*IN_DW-1:0]  s_tdata;
  logic                s_tvalid;
  logic                s_tready;
  logic [PHASE_DW-1:0] phase;
  logic [IN_DW:0]      mag;
  logic                m_tvalid;
  logic                m_tready;

  int checks   = 0;
  int failures = 0;

  dds_phase_detector #(.IN_DW(IN_DW), .PHASE_DW(PHASE_DW), .ITERATIONS(ITERATIONS)) dut (
    .clk                    (clk),
    .reset                  (reset),
    .s_axis_in_tdata        (s_tdata),
    .s_axis_in_tvalid       (s_tvalid),
    .s_axis_in_tready       (s_tready),
    .m_axis_out_phase_tdata (phase),
    .m_axis_out_mag_tdata   (mag),
    .m_axis_out_tvalid      (m_tvalid),
    .m_axis_out_tready      (m_tready)
  );

  always #5 clk = ~clk;

  // modulus != 0 compares on the circle of that size
  task automatic check(input string tag, input longint got, input longint exp,
                       input longint tol, input longint modulus);
    longint d;
    checks++;
    d = got - exp;
    if (modulus != 0) begin
      d = d % modulus;
      if (d < 0) d += modulus;
      if (d > modulus / 2) d -= modulus;
    end
    if (d < 0) d = -d;
    if (d > tol) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (tol %0d)", tag, got, exp, tol);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q, output int lat);
    int n;
    n = 0;
    while (!s_tready && n < 50) begin
      step();
      n++;
    end
    check("in_ready", longint'(s_tready), 1, 0, 0);
    s_tdata  = {16'(q), 16'(i)};
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    lat = 0;
    while (!m_tvalid && lat < 100) begin
      step();
      lat++;
    end
  endtask

  task automatic run(input string tag, input int i, input int q, input int exp_ph,
                     input int exp_mag);
    int lat;
    send(i, q, lat);
    check({tag, "_lat"}, lat, ITERATIONS + 1, 0, 0);
    check({tag, "_phase"}, longint'(phase), exp_ph, 4, 65536);
    if (exp_mag >= 0) check({tag, "_mag"}, longint'(mag), exp_mag, 8, 0);
    step();
  endtask

  int ramp [10] = '{0, 1, 8191, 16384, 30000, 32767, 40000, 49152, 60000, 65535};

  initial begin
    int  lat;
    int  seen;
    real a;
    reset    = 1'b1;
    s_tdata  = '0;
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    step();
    check("rst_in_ready", longint'(s_tready), 0, 0, 0);
    check("rst_out_valid", longint'(m_tvalid), 0, 0, 0);
    check("rst_phase", longint'(phase), 0, 0, 0);
    check("rst_mag", longint'(mag), 0, 0, 0);
    reset = 1'b0;
    #1;
    check("post_rst_ready", longint'(s_tready), 1, 0, 0);

    run("pos_i", 16384, 0, 0, 26981);
    run("pos_q", 0, 16384, 16384, 26981);
    run("neg_q", 0, -16384, 49152, 26981);
    run("neg_full", -32768, 0, 32768, 53963);
    run("zero", 0, 0, 0, 0);

    foreach (ramp[k]) begin
      a = 2.0 * PI * real'(ramp[k]) / 65536.0;
      run($sformatf("loop%0d", ramp[k]), int'(32000.0 * $cos(a)), int'(32000.0 * $sin(a)),
          ramp[k], -1);
    end

    // backpressure: result must hold while inputs are waved at the block
    m_tready = 1'b0;
    send(5000, 5000, lat);
    check("bp_lat", lat, ITERATIONS + 1, 0, 0);
    for (int c = 0; c < 10; c++) begin
      s_tdata  = {16'(-20000), 16'(-1234)};
      s_tvalid = 1'b1;
      step();
      check("bp_valid", longint'(m_tvalid), 1, 0, 0);
      check("bp_in_ready", longint'(s_tready), 0, 0, 0);
      check("bp_phase", longint'(phase), 8192, 4, 65536);
      check("bp_mag", longint'(mag), 11644, 8, 0);
    end
    s_tvalid = 1'b0;
    m_tready = 1'b1;
    step();
    check("bp_release", longint'(m_tvalid), 0, 0, 0);
    run("bp_next", 0, -16384, 49152, 26981);

    // reset at the fifth rotation cycle
    s_tdata  = {16'(0), 16'(16384)};
    s_tvalid = 1'b1;
    step();
    s_tvalid = 1'b0;
    repeat (5) step();
    reset = 1'b1;
    #1;
    check("mid_rst_valid", longint'(m_tvalid), 0, 0, 0);
    check("mid_rst_phase", longint'(phase), 0, 0, 0);
    check("mid_rst_mag", longint'(mag), 0, 0, 0);
    check("mid_rst_ready", longint'(s_tready), 0, 0, 0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("mid_rst_rel_ready", longint'(s_tready), 1, 0, 0);
    seen = 0;
    for (int c = 0; c < 20; c++) begin
      step();
      if (m_tvalid) seen++;
    end
    check("mid_rst_no_stale", seen, 0, 0, 0);
    run("after_rst", 0, 16384, 16384, 26981);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
